// File: rtl/mult_arbiter_if.sv
// Handshake bundle between the two operand sources, the shared-multiplier arbiter
// and the product consumer.
interface mult_arbiter_if;
    logic [1:0]  req_valid;
    logic [6:0]  req_a0;
    logic [6:0]  req_b0;
    logic [6:0]  req_a1;
    logic [6:0]  req_b1;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [13:0] resp_product;
    logic        resp_ready;
    logic [15:0] op_count;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, op_count
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, op_count
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 7x7 unsigned array multiplier between two requesters,
// with programmable settle time and a registered, back-pressurable response channel.
module seven_multiplier (
    input  logic [6:0]  a,
    input  logic [6:0]  b,
    output logic [13:0] p
);
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (b[i]) p = p + ({7'b0, a} << i);
        end
    end
endmodule

module mult_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    mult_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [6:0]  op_a;
    logic [6:0]  op_b;
    logic        cur_id;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic [13:0] prod;
    logic        resp_valid_q;
    logic        resp_id_q;
    logic [13:0] resp_product_q;
    logic [15:0] op_cnt;

    seven_multiplier u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // A lone requester always wins; on a tie the one not served last time goes.
    always_comb begin
        grant  = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
        accept = (state == IDLE) && (|bus.req_valid);
    end

    assign bus.req_ready    = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign bus.op_count     = op_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_a           <= '0;
            op_b           <= '0;
            cur_id         <= 1'b0;
            last_grant     <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_product_q <= '0;
            op_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant ? bus.req_a1 : bus.req_a0;
                        op_b       <= grant ? bus.req_b1 : bus.req_b0;
                        cur_id     <= grant;
                        last_grant <= grant;
                        cnt        <= SETTLE;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == 4'd1) begin
                        resp_product_q <= prod;
                        resp_id_q      <= cur_id;
                        resp_valid_q   <= 1'b1;
                        cnt            <= '0;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_cnt       <= op_cnt + 16'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: reset/idle, single op, contention, back-pressure,
// mid-operation reset and op_count wrap with a zero operand.
module tb_mult_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_arbiter_if bus ();

    mult_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         prev;
        logic [1:0] exp_rdy;

        bus.req_valid  = 2'b00;
        bus.req_a0     = '0;
        bus.req_b0     = '0;
        bus.req_a1     = '0;
        bus.req_b1     = '0;
        bus.resp_ready = 1'b1;
        prev           = 0;

        // Reset and idle
        repeat (3) tick;
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_op_count", 32'(bus.op_count), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_resp_valid", 32'(bus.resp_valid), 0);
            chk("idle_req_ready", 32'(bus.req_ready), 0);
            chk("idle_op_count", 32'(bus.op_count), 0);
        end

        // Single request 3x5 from requester 0
        bus.req_a0 = 7'd3; bus.req_b0 = 7'd5; bus.req_valid = 2'b01;
        #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
        tick;
        bus.req_valid = 2'b00; bus.req_a0 = 7'd99;
        #1 chk("single_calc_ready", 32'(bus.req_ready), 0);
        chk("single_t1_valid", 32'(bus.resp_valid), 0);
        tick;
        chk("single_t2_valid", 32'(bus.resp_valid), 0);
        tick;
        chk("single_t3_valid", 32'(bus.resp_valid), 1);
        chk("single_product", 32'(bus.resp_product), 15);
        chk("single_id", 32'(bus.resp_id), 0);
        tick;
        chk("single_valid_drop", 32'(bus.resp_valid), 0);
        chk("single_op_count", 32'(bus.op_count), 1);

        // Contention: last grant was 0, so requester 1 goes first
        bus.req_a0 = 7'd7;   bus.req_b0 = 7'd9;
        bus.req_a1 = 7'd127; bus.req_b1 = 7'd127;
        bus.req_valid = 2'b11;
        exp_rdy = 2'b10;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (bus.req_ready == 2'b00 && n < 8) begin
                tick; #1; n++;
            end
            chk("cont_accept_in_time", 32'(n < 8), 1);
            chk("cont_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (k > 0) chk("cont_spacing", 32'(cyc - prev), 4);
            prev = cyc;
            tick;
            chk("cont_calc_ready", 32'(bus.req_ready), 0);
            tick;
            tick;
            chk("cont_valid", 32'(bus.resp_valid), 1);
            chk("cont_id", 32'(bus.resp_id), 32'(exp_rdy[1]));
            chk("cont_product", 32'(bus.resp_product), exp_rdy[1] ? 16129 : 63);
            chk("cont_done_ready", 32'(bus.req_ready), 0);
            if (k == 3) bus.req_valid = 2'b00;
            tick;
            exp_rdy = ~exp_rdy;
        end
        #1 chk("cont_op_count", 32'(bus.op_count), 5);
        chk("cont_idle_ready", 32'(bus.req_ready), 0);

        // Back-pressure: 100x100 from requester 1 held in DONE for 20 cycles
        bus.resp_ready = 1'b0;
        bus.req_a1 = 7'd100; bus.req_b1 = 7'd100; bus.req_valid = 2'b10;
        #1 chk("bp_ready", 32'(bus.req_ready), 32'h2);
        tick;
        bus.req_valid = 2'b01; bus.req_a0 = 7'd1; bus.req_b0 = 7'd1;
        #1 chk("bp_calc_ready", 32'(bus.req_ready), 0);
        tick;
        tick;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(bus.resp_valid), 1);
            chk("bp_product", 32'(bus.resp_product), 10000);
            chk("bp_id", 32'(bus.resp_id), 1);
            chk("bp_no_ready", 32'(bus.req_ready), 0);
            tick;
        end
        bus.resp_ready = 1'b1; bus.req_valid = 2'b00;
        tick;
        chk("bp_valid_drop", 32'(bus.resp_valid), 0);
        chk("bp_op_count", 32'(bus.op_count), 6);

        // Reset during CALC of 50x2
        bus.req_a0 = 7'd50; bus.req_b0 = 7'd2; bus.req_valid = 2'b01;
        #1 chk("mrst_ready", 32'(bus.req_ready), 32'h1);
        tick;
        bus.req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("mrst_op_count", 32'(bus.op_count), 0);
        chk("mrst_product", 32'(bus.resp_product), 0);
        chk("mrst_id", 32'(bus.resp_id), 0);
        chk("mrst_valid", 32'(bus.resp_valid), 0);
        tick; tick; tick;
        chk("mrst_no_resp", 32'(bus.resp_valid), 0);
        rst_n = 1'b1;
        bus.req_a1 = 7'd3; bus.req_b1 = 7'd3; bus.req_valid = 2'b11;
        #1 chk("mrst_tie_ready", 32'(bus.req_ready), 32'h1);
        tick;
        bus.req_valid = 2'b00;
        tick;
        tick;
        chk("mrst_post_valid", 32'(bus.resp_valid), 1);
        chk("mrst_post_id", 32'(bus.resp_id), 0);
        chk("mrst_post_product", 32'(bus.resp_product), 100);
        chk("mrst_post_count_pre", 32'(bus.op_count), 0);
        tick;
        chk("mrst_post_count", 32'(bus.op_count), 1);

        // Wrap: preload count to 0xFFFF, then 0x127
        force dut.op_cnt = 16'hFFFF;
        #1 release dut.op_cnt;
        #1 chk("wrap_preload", 32'(bus.op_count), 32'hFFFF);
        bus.req_a0 = 7'd0; bus.req_b0 = 7'd127; bus.req_valid = 2'b01;
        #1 chk("wrap_ready", 32'(bus.req_ready), 32'h1);
        tick;
        bus.req_valid = 2'b00;
        tick;
        tick;
        chk("wrap_valid", 32'(bus.resp_valid), 1);
        chk("wrap_product", 32'(bus.resp_product), 0);
        chk("wrap_count_hold", 32'(bus.op_count), 32'hFFFF);
        tick;
        chk("wrap_count", 32'(bus.op_count), 0);
        chk("wrap_valid_drop", 32'(bus.resp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
